// File: rtl/str_arb.sv
// Round-robin arbiter: N_SRC AXI-Stream sources share one registered output beat with source ID.
// Optional per-source grant counters are enabled with `define STR_ARB_CNT_EN.
module str_arb #(
    parameter int unsigned N_PKT    = 3,
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_areset,
    input  logic [N_SRC-1:0]           src_en,
    input  logic [32*N_PKT*N_SRC-1:0]  s_axis_tdata,
    input  logic [N_SRC-1:0]           s_axis_tvalid,
    output logic [N_SRC-1:0]           s_axis_tready,
    output logic [32*N_PKT-1:0]        m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic                       busy
`ifdef STR_ARB_CNT_EN
    ,
    input  logic                       cnt_clr,
    output logic [32*N_SRC-1:0]        grant_cnt
`endif
);

    localparam int unsigned BW = 32 * N_PKT;
    localparam int unsigned PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StAccept, StHold} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [BW-1:0]     tdata_q, tdata_d;
    logic [ID_WIDTH-1:0] tid_q, tid_d;
    logic              tvalid_q, tvalid_d;

    logic [N_SRC-1:0]  req;
    logic [PW-1:0]     winner;
    logic              found;
    logic              xfer;

    assign req  = s_axis_tvalid & src_en;
    assign xfer = (state_q == StAccept) && s_axis_tvalid[grant_q];

    // Rotating priority search starting at ptr_q and wrapping past N_SRC-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            int unsigned idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        tvalid_d = tvalid_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                if (xfer) begin
                    tdata_d  = s_axis_tdata[grant_q*BW +: BW];
                    tid_d    = ID_WIDTH'(grant_q);
                    tvalid_d = 1'b1;
                    state_d  = StHold;
                end else begin
                    // Source dropped valid while granted: give up without advancing ptr.
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (tvalid_q && m_axis_tready) begin
                    tvalid_d = 1'b0;
                    ptr_d    = (grant_q == PW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            tdata_q  <= '0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == StAccept) s_axis_tready[grant_q] = 1'b1;
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tid    = tid_q;
    assign busy          = (state_q != StIdle);

`ifdef STR_ARB_CNT_EN
    logic [32*N_SRC-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d[grant_q*32 +: 32] = cnt_q[grant_q*32 +: 32] + 32'd1;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_str_arb.sv
// Self-checking bench for str_arb: directed vector table, corner sequences, random vs. model.
// Counter checks are compiled in when STR_ARB_CNT_EN is defined.
module tb_str_arb;

    localparam int N_SRC = 4;
    localparam int BW    = 96;

    localparam logic [95:0] S0 = 96'h00000010_00000011_00000012;
    localparam logic [95:0] S1 = 96'h00000020_00000021_00000022;
    localparam logic [95:0] S2 = 96'h00000003_00000002_00000001;
    localparam logic [95:0] S3 = 96'h00000030_00000031_00000032;
    localparam logic [383:0] DATA = {S3, S2, S1, S0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   src_en = 4'hF;
    logic [383:0] tdata = DATA;
    logic [3:0]   tvalid = 4'h0;
    logic [3:0]   tready_s;
    logic [95:0]  mdata;
    logic         mvalid;
    logic         mready = 1'b1;
    logic [1:0]   mtid;
    logic         busy;
`ifdef STR_ARB_CNT_EN
    logic         cnt_clr = 1'b0;
    logic [127:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    str_arb #(.N_PKT(3), .N_SRC(4), .ID_WIDTH(2)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .src_en       (src_en),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready_s),
        .m_axis_tdata (mdata),
        .m_axis_tvalid(mvalid),
        .m_axis_tready(mready),
        .m_axis_tid   (mtid),
        .busy         (busy)
`ifdef STR_ARB_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Waits up to 20 cycles for an output beat; returns at the negedge where mvalid is seen.
    task automatic wait_beat(input string name);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mvalid) got = 1;
        end
        if (!got) chk({name, " timeout"}, 0, 1);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_phase;   // 0 waiting for a request, 1 granted, 2 beat held
    int          m_ptr, m_grant, m_tid;
    logic [95:0] m_data;
    bit          m_valid;
    int unsigned m_cnt[4];

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < N_SRC; k++)
            if (req[(ptr + k) % N_SRC]) return (ptr + k) % N_SRC;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_grant = 0; m_tid = 0; m_data = '0; m_valid = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input bit clr);
        bit took;
        took = (m_phase == 1) && tvalid[m_grant];
        if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        else if (took) m_cnt[m_grant] = m_cnt[m_grant] + 1;
        if (m_phase == 0) begin
            if ((tvalid & src_en) != 0) begin
                m_grant = rr_pick(tvalid & src_en, m_ptr);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (took) begin
                m_data  = tdata[m_grant*BW +: BW];
                m_tid   = m_grant;
                m_valid = 1;
                m_phase = 2;
            end else m_phase = 0;
        end else if (mready) begin
            m_valid = 0;
            m_ptr   = (m_grant + 1) % N_SRC;
            m_phase = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  en;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_tid;
        logic [95:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic run_seq(input string name, input logic [3:0] v, input logic [3:0] e,
                           input int n, input int exp_tid[6], input logic [3:0] forbid);
        int seen = 0;
        int last = -1;
        logic [3:0] rdy_or = '0;
        do_reset();
        tvalid = v; src_en = e; mready = 1'b1;
        for (int c = 0; c < 60 && seen < n; c++) begin
            @(negedge clk);
            rdy_or |= tready_s;
            chk({name, " onehot"}, 128'($onehot0(tready_s)), 1);
            if (mvalid) begin
                chk($sformatf("%s tid%0d", name, seen), mtid, exp_tid[seen]);
                if (last >= 0) chk($sformatf("%s gap%0d", name, seen), c - last, 3);
                last = c;
                seen++;
            end
        end
        chk({name, " beats"}, seen, n);
        chk({name, " forbidden ready"}, rdy_or & forbid, 0);
        tvalid = 4'h0;
    endtask

    initial begin
        vec_t v;
        int   seq_a[6];
        int   seq_b[6];

        vecs[0] = '{4'b0100, 4'b1111, 4'b0100, 2'd2, S2};
        vecs[1] = '{4'b1111, 4'b1111, 4'b0001, 2'd0, S0};
        vecs[2] = '{4'b1010, 4'b1111, 4'b0010, 2'd1, S1};
        vecs[3] = '{4'b1111, 4'b1010, 4'b0010, 2'd1, S1};
        vecs[4] = '{4'b1000, 4'b1111, 4'b1000, 2'd3, S3};
        vecs[5] = '{4'b0110, 4'b0011, 4'b0010, 2'd1, S1};

        // Single-beat latency per vector: ready in cycle 1, beat in cycle 2, idle afterwards.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            tvalid = 4'h0; src_en = v.en; tdata = DATA; mready = 1'b1;
            do_reset();
            tvalid = v.valid;
            @(negedge clk);
            chk($sformatf("v%0d reset outs", i), {mvalid, mtid, mdata, tready_s, busy}, '0);
            @(negedge clk);
            chk($sformatf("v%0d c1 ready", i), tready_s, v.exp_rdy);
            chk($sformatf("v%0d c1 busy/valid", i), {busy, mvalid}, 2'b10);
            @(posedge clk);
            #1 tvalid = 4'h0;
            @(negedge clk);
            chk($sformatf("v%0d c2 beat", i), {mvalid, mtid, mdata, tready_s},
                {1'b1, v.exp_tid, v.exp_data, 4'b0000});
            @(negedge clk);
            chk($sformatf("v%0d c3 idle", i), {busy, mvalid, mdata}, {1'b0, 1'b0, v.exp_data});
            @(negedge clk);
            chk($sformatf("v%0d c4 idle", i), busy, 0);
        end

        // Async reset in HOLD after ptr advanced to 1; next grant must restart at source 0.
        tvalid = 4'h0; src_en = 4'hF; mready = 1'b1;
        do_reset();
        tvalid = 4'hF;
        wait_beat("rst first");
        chk("rst first tid", mtid, 0);
        @(posedge clk);
        #1 mready = 1'b0;
        wait_beat("rst second");
        chk("rst second tid", mtid, 1);
        #2 rst = 1'b1;
        #1 chk("async reset outs", {mvalid, mtid, mdata, tready_s, busy}, '0);
        @(posedge clk);
        #1 begin rst = 1'b0; mready = 1'b1; end
        wait_beat("rst after");
        chk("rst after tid", mtid, 0);

        // Reader stalls for 10 cycles with a beat from source 1 held.
        tvalid = 4'h0; mready = 1'b0;
        do_reset();
        tvalid = 4'b0010;
        wait_beat("stall");
        tvalid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall hold%0d", i), {mvalid, mtid, mdata, tready_s},
                {1'b1, 2'd1, S1, 4'b0000});
            @(negedge clk);
        end
        mready = 1'b1;
        @(negedge clk);
        chk("stall release", {mvalid, busy}, 2'b00);
        wait_beat("stall next");
        chk("stall next beat", {mtid, mdata}, {2'd2, S2});
        tvalid = 4'h0;

        seq_a = '{0, 1, 2, 3, 0, 1};
        run_seq("all", 4'hF, 4'hF, 6, seq_a, 4'b0000);
        seq_b = '{1, 3, 1, 3, 0, 0};
        run_seq("en1010", 4'hF, 4'b1010, 4, seq_b, 4'b0101);

`ifdef STR_ARB_CNT_EN
        tvalid = 4'h0; src_en = 4'hF; mready = 1'b1; cnt_clr = 1'b0;
        do_reset();
        @(negedge clk);
        chk("cnt reset", grant_cnt, '0);
        force dut.cnt_q = 128'h00000000_00000000_00000000_FFFFFFFF;
        #1 release dut.cnt_q;
        @(negedge clk);
        chk("cnt preload", grant_cnt[31:0], 32'hFFFFFFFF);
        tvalid = 4'b0001;
        wait_beat("cnt wrap");
        chk("cnt wrap", grant_cnt[31:0], 0);
        tvalid = 4'b0010;
        begin
            bit hit = 0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                if (tready_s[1]) hit = 1;
            end
            chk("cnt clr reach accept", hit, 1);
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("cnt clr vs incr", {mvalid, grant_cnt[63:32]}, {1'b1, 32'd0});
        wait_beat("cnt incr");
        chk("cnt incr src1", grant_cnt[63:32], 1);
        tvalid = 4'h0;
`endif

        // Random stimulus against the model.
        tvalid = 4'h0;
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bit clr;
            tvalid = 4'($urandom);
            src_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            mready = ($urandom_range(0, 1) == 1);
            for (int w = 0; w < 12; w++) tdata[w*32 +: 32] = $urandom;
            clr = ($urandom_range(0, 15) == 0);
`ifdef STR_ARB_CNT_EN
            cnt_clr = clr;
`endif
            @(negedge clk);
            chk($sformatf("rnd%0d ready", c), tready_s,
                (m_phase == 1) ? (128'd1 << m_grant) : 128'd0);
            chk($sformatf("rnd%0d out", c), {mvalid, mtid, mdata, busy},
                {m_valid, 2'(m_tid), m_data, (m_phase != 0)});
`ifdef STR_ARB_CNT_EN
            chk($sformatf("rnd%0d cnt", c), grant_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
            @(posedge clk);
            model_step(clr);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
